// File: rtl/hash_pkg.sv
// Shared types and widths for the hash job sequencer and its digest serializer.
package hash_pkg;

   localparam int DIGEST_W = 256;
   localparam int BYTE_W   = 8;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_HASH    = 2'd2,
      ST_SEND    = 2'd3
   } hash_state_t;

endpackage

// File: rtl/digest_serializer.sv
// Holds a captured digest and hands it out MSB byte first over a valid/ready link.
module digest_serializer
   import hash_pkg::*;
#(
   parameter int DIGEST_BYTES = 32
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                load,
   input  logic [DIGEST_W-1:0] digest,
   input  logic                ready,
   output logic                valid,
   output logic [BYTE_W-1:0]   tx_byte,
   output logic                last
);

   localparam int CW = $clog2(DIGEST_BYTES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DIGEST_BYTES - 1);

   logic [DIGEST_W-1:0] shreg;
   logic [CW-1:0]       cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg <= '0;
         cnt   <= '0;
         valid <= 1'b0;
      end else if (load) begin
         shreg <= digest;
         cnt   <= '0;
         valid <= 1'b1;
      end else if (valid && ready) begin
         if (last) begin
            shreg <= '0;
            cnt   <= '0;
            valid <= 1'b0;
         end else begin
            shreg <= shreg << BYTE_W;
            cnt   <= cnt + 1'b1;
         end
      end
   end

   // The head byte only moves on a transfer, so it is stable through a stall.
   assign tx_byte = shreg[DIGEST_W-1 -: BYTE_W];
   assign last    = valid && (cnt == CNT_LAST);

endmodule

// File: rtl/hash_job_ctrl.sv
// Collects a message from the UART, kicks the hasher once and streams the digest back.
//
//   state    | meaning
//   IDLE     | waiting for the first byte of a message
//   COLLECT  | filling byte lanes, idle timer running between bytes
//   HASH     | start pulsed on entry, waiting for the hasher to finish
//   SEND     | digest bytes handed to the UART transmitter
module hash_job_ctrl
   import hash_pkg::*;
#(
   parameter int MSG_BYTES      = 8,
   parameter int DIGEST_BYTES   = 32,
   parameter int TIMEOUT_CYCLES = 5_000_000
) (
   input  logic                          i_Clk,
   input  logic                          i_rst,
   input  logic                          i_rx_valid,
   input  logic [BYTE_W-1:0]             i_rx_byte,
   output logic                          o_hash_start,
   output logic [MSG_BYTES*BYTE_W-1:0]   o_hash_msg,
   input  logic                          i_hash_done,
   input  logic [DIGEST_W-1:0]           i_hash_digest,
   output logic                          o_tx_valid,
   output logic [BYTE_W-1:0]             o_tx_byte,
   input  logic                          i_tx_ready,
   output logic                          o_busy,
   output logic [1:0]                    o_state,
   output logic                          o_err_timeout,
   output logic                          o_err_overrun
);

   localparam int MSG_W = MSG_BYTES * BYTE_W;
   localparam int RCW   = $clog2(MSG_BYTES + 1);
   localparam int TW    = $clog2(TIMEOUT_CYCLES);
   localparam int LW    = (MSG_W > 2) ? $clog2(MSG_W) : 1;

   localparam logic [RCW-1:0] RX_LAST = RCW'(MSG_BYTES - 1);
   localparam logic [RCW-1:0] RX_ONE  = RCW'(1);
   // The timer fires on the edge that would carry it to TIMEOUT_CYCLES-1.
   localparam logic [TW-1:0]  TO_FIRE = TW'(TIMEOUT_CYCLES - 2);

   hash_state_t      state;
   logic [RCW-1:0]   rx_cnt;
   logic [TW-1:0]    to_cnt;
   logic [LW-1:0]    lane_lo;
   logic [MSG_W-1:0] rx_wide;
   logic             ser_load;
   logic             ser_last;

   always_comb begin
      lane_lo = LW'((MSG_BYTES - 1 - int'(rx_cnt)) * BYTE_W);
      rx_wide = MSG_W'(i_rx_byte);
   end

   assign ser_load = (state == ST_HASH) && i_hash_done;

   always_ff @(posedge i_Clk or posedge i_rst) begin
      if (i_rst) begin
         state         <= ST_IDLE;
         rx_cnt        <= '0;
         to_cnt        <= '0;
         o_hash_msg    <= '0;
         o_hash_start  <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_overrun <= 1'b0;
      end else begin
         o_hash_start  <= 1'b0;
         o_err_timeout <= 1'b0;
         o_err_overrun <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (i_rx_valid) begin
                  o_hash_msg <= rx_wide << (MSG_W - BYTE_W);
                  rx_cnt     <= RX_ONE;
                  to_cnt     <= '0;
                  if (MSG_BYTES == 1) begin
                     state        <= ST_HASH;
                     o_hash_start <= 1'b1;
                  end else begin
                     state <= ST_COLLECT;
                  end
               end
            end
            ST_COLLECT: begin
               // A byte on the expiry cycle wins over the timeout.
               if (i_rx_valid) begin
                  o_hash_msg <= o_hash_msg | (rx_wide << lane_lo);
                  rx_cnt     <= rx_cnt + 1'b1;
                  to_cnt     <= '0;
                  if (rx_cnt == RX_LAST) begin
                     state        <= ST_HASH;
                     o_hash_start <= 1'b1;
                  end
               end else if (to_cnt == TO_FIRE) begin
                  o_err_timeout <= 1'b1;
                  o_hash_msg    <= '0;
                  rx_cnt        <= '0;
                  to_cnt        <= '0;
                  state         <= ST_IDLE;
               end else begin
                  to_cnt <= to_cnt + 1'b1;
               end
            end
            ST_HASH: begin
               o_err_overrun <= i_rx_valid;
               if (i_hash_done) begin
                  state <= ST_SEND;
               end
            end
            ST_SEND: begin
               o_err_overrun <= i_rx_valid;
               if (ser_last && i_tx_ready) begin
                  state  <= ST_IDLE;
                  rx_cnt <= '0;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   assign o_state = state;
   assign o_busy  = (state != ST_IDLE);

   digest_serializer #(
      .DIGEST_BYTES(DIGEST_BYTES)
   ) u_ser (
      .clk     (i_Clk),
      .rst     (i_rst),
      .load    (ser_load),
      .digest  (i_hash_digest),
      .ready   (i_tx_ready),
      .valid   (o_tx_valid),
      .tx_byte (o_tx_byte),
      .last    (ser_last)
   );

endmodule
